// File: rtl/pes_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : pes_cla_pipe_adder
// Description : Two-stage pipelined two-level carry-lookahead adder/subtractor
//               with valid/ready handshaking on both sides. Stage 1 forms the
//               per-bit and per-4-bit-group propagate/generate terms. Stage 2
//               resolves the group carries by a second lookahead level and
//               produces the sum, carry-out, word P/G and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module pes_cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             PG,
  output logic             GG,
  output logic             OVF
);

  localparam int NGRP = WIDTH / BLK;

  // Elaboration-time guard on the legal parameter space.
  if ((BLK != 4) || (WIDTH < 4) || ((WIDTH % BLK) != 0)) begin : g_param_check
    $error("pes_cla_pipe_adder: WIDTH must be a multiple of 4 (>= 4) and BLK must be 4");
  end

  // Flattened lookahead carry into position n:
  //   c[n] = OR_{j<n} ( gen[j] & AND_{j<m<n} prop[m] )  |  ( AND_{m<n} prop[m] & cin )
  // Every term is an independent product, so no carry ripples between positions.
  function automatic logic f_carry(
    input logic [WIDTH-1:0] gen,
    input logic [WIDTH-1:0] prop,
    input logic             cin,
    input int               n
  );
    logic c;
    logic run;
    c = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      if (j < n) begin
        run = gen[j];
        for (int m = 0; m < WIDTH; m++) begin
          if ((m > j) && (m < n)) run = run & prop[m];
        end
        c = c | run;
      end
    end
    run = cin;
    for (int m = 0; m < WIDTH; m++) begin
      if (m < n) run = run & prop[m];
    end
    return c | run;
  endfunction

  // --------------------------------------------------------------------------
  // Handshake control
  // --------------------------------------------------------------------------
  logic s1_valid_q;
  logic out_valid_q;
  logic ld1;
  logic ld2;

  // Stage 2 may load whenever its content is absent or being consumed; stage 1
  // may load whenever it is empty or draining into stage 2 (bubble collapse).
  assign ld2      = !out_valid_q || out_ready;
  assign ld1      = !s1_valid_q || ld2;
  assign in_ready = ld1;

  // --------------------------------------------------------------------------
  // Stage 1 combinational: effective operands, bit and group P/G
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] be_d;
  logic             ce_d;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] g_d;
  logic [NGRP-1:0]  grp_p_d;
  logic [NGRP-1:0]  grp_g_d;

  // Subtraction is A + ~B + ~Cin, i.e. A - B - Cin in two's complement.
  assign be_d = sub ? ~B : B;
  assign ce_d = sub ? ~Cin : Cin;
  assign p_d  = A ^ be_d;
  assign g_d  = A & be_d;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp_pg
    assign grp_p_d[k] = &p_d[k*BLK +: BLK];
    assign grp_g_d[k] = f_carry(g_d >> (k*BLK), p_d >> (k*BLK), 1'b0, BLK);
  end

  // --------------------------------------------------------------------------
  // Stage 1 registers. Operand A itself is not kept: p and g hold everything
  // stage 2 needs to form the sum and carries.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] g_q;
  logic [NGRP-1:0]  grp_p_q;
  logic [NGRP-1:0]  grp_g_q;
  logic             ce_q;

  // Capture the lookahead terms of an accepted operand set; track occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      g_q        <= '0;
      grp_p_q    <= '0;
      grp_g_q    <= '0;
      ce_q       <= 1'b0;
    end else if (ld1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        p_q     <= p_d;
        g_q     <= g_d;
        grp_p_q <= grp_p_d;
        grp_g_q <= grp_g_d;
        ce_q    <= ce_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 combinational: second lookahead level and result formation
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] grp_g_pad;
  logic [WIDTH-1:0] grp_p_pad;
  logic [NGRP-1:0]  grp_c;
  logic [WIDTH-1:0] c_bit;
  logic [WIDTH-1:0] s_d;
  logic             pg_d;
  logic             gg_d;
  logic             cout_d;
  logic             ovf_d;

  assign grp_g_pad = {{(WIDTH-NGRP){1'b0}}, grp_g_q};
  assign grp_p_pad = {{(WIDTH-NGRP){1'b0}}, grp_p_q};

  // Carry into each 4-bit group, resolved directly from the group terms.
  for (genvar k = 0; k < NGRP; k++) begin : g_grp_carry
    assign grp_c[k] = f_carry(grp_g_pad, grp_p_pad, ce_q, k);
  end

  // Carry into each bit from its group carry-in, then sum bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit_sum
    localparam int K = i / BLK;
    localparam int O = i % BLK;
    assign c_bit[i] = f_carry(g_q >> (K*BLK), p_q >> (K*BLK), grp_c[K], O);
    assign s_d[i]   = p_q[i] ^ c_bit[i];
  end

  assign pg_d   = &p_q;
  assign gg_d   = f_carry(grp_g_pad, grp_p_pad, 1'b0, NGRP);
  assign cout_d = gg_d | (pg_d & ce_q);
  assign ovf_d  = c_bit[WIDTH-1] ^ cout_d;

  // --------------------------------------------------------------------------
  // Stage 2 registers (outputs)
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             pg_q;
  logic             gg_q;
  logic             ovf_q;

  // Load results when the output slot frees up; hold them steady under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      pg_q        <= 1'b0;
      gg_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (ld2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s_q    <= s_d;
        cout_q <= cout_d;
        pg_q   <= pg_d;
        gg_q   <= gg_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign Cout      = cout_q;
  assign PG        = pg_q;
  assign GG        = gg_q;
  assign OVF       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pes_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pes_cla_pipe_adder
// Description : Directed, table-driven bench for pes_cla_pipe_adder with a
//               16-bit instance and a 4-bit instance sharing clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pes_cla_pipe_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        pg;
    logic        gg;
    logic        ovf;
  } vec_t;

  localparam int NVEC = 9;

  logic clk = 1'b0;
  logic rst_n;

  // 16-bit instance signals
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, s16;
  logic        cin16, sub16, cout16, pg16, gg16, ovf16;

  // 4-bit instance signals
  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]  a4, b4, s4;
  logic        cin4, sub4, cout4, pg4, gg4, ovf4;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  pes_cla_pipe_adder #(.WIDTH(16), .BLK(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .A(a16), .B(b16), .Cin(cin16), .sub(sub16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .S(s16), .Cout(cout16), .PG(pg16), .GG(gg16), .OVF(ovf16)
  );

  pes_cla_pipe_adder #(.WIDTH(4), .BLK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .A(a4), .B(b4), .Cin(cin4), .sub(sub4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .S(s4), .Cout(cout4), .PG(pg4), .GG(gg4), .OVF(ovf4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive16(input logic v, input vec_t t);
    in_valid16 = v;
    a16        = t.a;
    b16        = t.b;
    cin16      = t.cin;
    sub16      = t.sub;
  endtask

  task automatic chk_out16(input string tag, input int i);
    chk({tag, " out_valid"}, out_valid16, 1'b1);
    chk({tag, " S"},         s16,         vecs[i].s);
    chk({tag, " Cout"},      cout16,      vecs[i].cout);
    chk({tag, " PG"},        pg16,        vecs[i].pg);
    chk({tag, " GG"},        gg16,        vecs[i].gg);
    chk({tag, " OVF"},       ovf16,       vecs[i].ovf);
  endtask

  initial begin
    int acc;

    //               a         b       cin   sub   s         cout  pg    gg    ovf
    vecs[0] = '{16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h00FF, 16'hFF00, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_n       = 1'b0;
    in_valid16  = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    out_ready16 = 1'b1;
    in_valid4   = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    out_ready4  = 1'b1;

    // Reset state
    #2;
    chk("rst out_valid16", out_valid16, 1'b0);
    chk("rst S16",         s16,         16'h0000);
    chk("rst Cout16",      cout16,      1'b0);
    chk("rst PG16",        pg16,        1'b0);
    chk("rst GG16",        gg16,        1'b0);
    chk("rst OVF16",       ovf16,       1'b0);
    chk("rst in_ready16",  in_ready16,  1'b1);
    chk("rst out_valid4",  out_valid4,  1'b0);
    chk("rst in_ready4",   in_ready4,   1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single operand sets: empty after one edge, result after the second
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive16(1'b1, vecs[i]);
      chk($sformatf("single%0d in_ready", i), in_ready16, 1'b1);
      @(negedge clk);
      in_valid16 = 1'b0;
      chk($sformatf("single%0d early out_valid", i), out_valid16, 1'b0);
      @(negedge clk);
      chk_out16($sformatf("single%0d", i), i);
    end
    @(negedge clk);
    chk("drain out_valid", out_valid16, 1'b0);

    // Back-to-back stream at full throughput
    for (int k = 0; k < NVEC + 2; k++) begin
      @(negedge clk);
      if (k < NVEC) drive16(1'b1, vecs[k]);
      else in_valid16 = 1'b0;
      chk($sformatf("stream%0d in_ready", k), in_ready16, 1'b1);
      if (k >= 2) chk_out16($sformatf("stream%0d", k), k - 2);
      else chk($sformatf("stream%0d out_valid", k), out_valid16, 1'b0);
    end
    @(negedge clk);
    chk("stream drain out_valid", out_valid16, 1'b0);

    // Backpressure: output stalled, source holds data while not accepted
    out_ready16 = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive16(1'b1, vecs[acc]);
      chk($sformatf("bp cycle%0d in_ready", c), in_ready16, (c < 2) ? 1'b1 : 1'b0);
      if (c >= 2) begin
        chk($sformatf("bp cycle%0d out_valid", c), out_valid16, 1'b1);
        chk($sformatf("bp cycle%0d held S", c),    s16,         vecs[0].s);
        chk($sformatf("bp cycle%0d held Cout", c), cout16,      vecs[0].cout);
      end
      if (in_ready16) acc++;
    end
    chk("bp accepted count", acc, 2);
    @(negedge clk);
    in_valid16  = 1'b0;
    out_ready16 = 1'b1;
    chk_out16("bp first", 0);
    @(negedge clk);
    chk_out16("bp second", 1);
    @(negedge clk);
    chk("bp drain out_valid", out_valid16, 1'b0);

    // Reset asserted mid-stream: effect must be immediate and in-flight data lost
    @(negedge clk);
    drive16(1'b1, vecs[4]);
    @(negedge clk);
    drive16(1'b1, vecs[5]);
    @(negedge clk);
    drive16(1'b1, vecs[6]);
    chk("pre-rst out_valid", out_valid16, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid16, 1'b0);
    chk("midrst S",         s16,         16'h0000);
    chk("midrst in_ready",  in_ready16,  1'b1);
    chk("midrst Cout",      cout16,      1'b0);
    chk("midrst GG",        gg16,        1'b0);
    in_valid16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst out_valid", out_valid16, 1'b0);
    drive16(1'b1, vecs[7]);
    @(negedge clk);
    in_valid16 = 1'b0;
    chk("postrst early out_valid", out_valid16, 1'b0);
    @(negedge clk);
    chk_out16("postrst first", 7);
    @(negedge clk);
    chk("postrst drain out_valid", out_valid16, 1'b0);

    // 4-bit instance, back-to-back operand sets
    @(negedge clk);
    in_valid4 = 1'b1; a4 = 4'b1101; b4 = 4'b1010; cin4 = 1'b1; sub4 = 1'b0;
    @(negedge clk);
    in_valid4 = 1'b1; a4 = 4'b1110; b4 = 4'b1001; cin4 = 1'b0; sub4 = 1'b0;
    @(negedge clk);
    in_valid4 = 1'b0;
    chk("w4 first out_valid", out_valid4, 1'b1);
    chk("w4 first S",         s4,         4'b1000);
    chk("w4 first Cout",      cout4,      1'b1);
    chk("w4 first PG",        pg4,        1'b0);
    chk("w4 first GG",        gg4,        1'b1);
    chk("w4 first OVF",       ovf4,       1'b0);
    @(negedge clk);
    chk("w4 second out_valid", out_valid4, 1'b1);
    chk("w4 second S",         s4,         4'b0111);
    chk("w4 second Cout",      cout4,      1'b1);
    chk("w4 second GG",        gg4,        1'b1);
    chk("w4 second OVF",       ovf4,       1'b1);
    @(negedge clk);
    chk("w4 drain out_valid", out_valid4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
